// File: rtl/ffd_pkg.sv
// ============================================================================
// Module  : ffd_pkg
// Brief   : Shared constants for the ffd storage element.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ffd_pkg;

  // Default data width of a single flip-flop; wider registers raise WIDTH.
  localparam int unsigned FFD_DEFAULT_WIDTH = 1;

endpackage : ffd_pkg

`default_nettype wire

// File: rtl/ffd.sv
// ============================================================================
// Module  : ffd
// Brief   : Rising-edge D flip-flop, WIDTH bits wide, with synchronous
//           active-high reset (dominant) and synchronous active-high preset.
//           Provides true and complementary outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ffd
  import ffd_pkg::*;
#(
  parameter int unsigned WIDTH = FFD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] notq
);

  logic [WIDTH-1:0] r_q;

  // Storage: reset beats preset, preset beats data; no power-on initialiser,
  // so r_q stays X until the first qualifying edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (preset) begin
      r_q <= '1;
    end else begin
      r_q <= d;
    end
  end

  // Both outputs derive from the same register so they can never disagree.
  assign q    = r_q;
  assign notq = ~r_q;

endmodule : ffd

`default_nettype wire

// File: tb/tb_ffd.sv
// ============================================================================
// Module  : tb_ffd
// Brief   : Directed self-checking bench for ffd at WIDTH=1 and WIDTH=4.
//           Both instances share clk/reset/preset and receive separate data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ffd;

  logic       clk;
  logic       reset;
  logic       preset;
  logic [0:0] d1;
  logic [0:0] q1;
  logic [0:0] notq1;
  logic [3:0] d4;
  logic [3:0] q4;
  logic [3:0] notq4;

  int n_checks;
  int n_errors;

  ffd #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .preset (preset),
    .d      (d1),
    .q      (q1),
    .notq   (notq1)
  );

  ffd #(.WIDTH(4)) u_dut4 (
    .clk    (clk),
    .reset  (reset),
    .preset (preset),
    .d      (d4),
    .q      (q4),
    .notq   (notq4)
  );

  // Single comparison point.
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check both instances, true and complementary outputs.
  task automatic check_all(input string tag, input logic e1, input logic [3:0] e4);
    check({tag, ".q1"},    {3'b000, q1},    {3'b000, e1});
    check({tag, ".notq1"}, {3'b000, notq1}, {3'b000, ~e1});
    check({tag, ".q4"},    q4,              e4);
    check({tag, ".notq4"}, notq4,           ~e4);
  endtask

  // Rising edge from a low clock, sampled 1 time unit later.
  task automatic rise();
    #5 clk = 1'b1;
    #1;
  endtask

  // Falling edge, sampled 1 time unit later.
  task automatic fall();
    #4 clk = 1'b0;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk      = 1'b0;
    reset    = 1'b0;
    preset   = 1'b0;
    d1       = 1'b0;
    d4       = 4'h0;

    // Reset with X on data: X must not reach q.
    reset = 1'b1; preset = 1'b0; d1 = 1'bx; d4 = 4'bxxxx;
    rise();
    check_all("reset", 1'b0, 4'h0);
    fall();

    // Capture.
    reset = 1'b0; d1 = 1'b1; d4 = 4'hA;
    rise();
    check_all("capture", 1'b1, 4'hA);

    // Clock held high: data changes do nothing.
    d1 = 1'b0; d4 = 4'h3;
    #10;
    check_all("hold_high", 1'b1, 4'hA);
    fall();
    check_all("hold_fall", 1'b1, 4'hA);

    // Capture 0/3, then set 1/C while high; falling edge must not load it.
    rise();
    check_all("capture0", 1'b0, 4'h3);
    d1 = 1'b1; d4 = 4'hC;
    fall();
    check_all("fall_hold", 1'b0, 4'h3);
    rise();
    check_all("fall_next", 1'b1, 4'hC);
    fall();

    // Bring q to 0, then preset with d=0.
    d1 = 1'b0; d4 = 4'h0;
    rise();
    check_all("clear", 1'b0, 4'h0);
    fall();
    preset = 1'b1;
    rise();
    check_all("preset", 1'b1, 4'hF);
    fall();
    preset = 1'b0; d1 = 1'b0; d4 = 4'h0;
    rise();
    check_all("preset_rel", 1'b0, 4'h0);
    fall();

    // Preset with X on data: X must not reach q.
    preset = 1'b1; d1 = 1'bx; d4 = 4'bxxxx;
    rise();
    check_all("preset_x", 1'b1, 4'hF);
    fall();

    // Load a non-trivial value, then reset+preset together: reset wins.
    preset = 1'b0; d1 = 1'b1; d4 = 4'h6;
    rise();
    check_all("load6", 1'b1, 4'h6);
    fall();
    reset = 1'b1; preset = 1'b1; d1 = 1'b1; d4 = 4'hF;
    rise();
    check_all("priority", 1'b0, 4'h0);
    fall();
    reset = 1'b0; preset = 1'b0; d1 = 1'b1; d4 = 4'h9;
    rise();
    check_all("release", 1'b1, 4'h9);
    fall();

    // X on data with no override propagates.
    d1 = 1'bx; d4 = 4'bxxxx;
    rise();
    check_all("data_x", 1'bx, 4'bxxxx);
    fall();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_ffd

`default_nettype wire
